fsm_step_driver: RTL and testbench
==================================

Name: fsm_step_driver

Overview:
- Initiator for the five-position pulse-counter FSM (S0..S4, advanced by `a` while `enable` is high, one-hot position out).
- Accepts a target position on a valid/ready command port.
- Issues single `a` pulses aligned to `enable` until the counter's one-hot feedback equals the target.
- Checks each step against the expected next position and flags an error on mismatch or illegal feedback.

Parameters:
- NUM_POS, 5, number of counter positions; position k is one-hot bit k-1, position 0 is all-zero.
- POS_W, 4, one-hot feedback width (NUM_POS-1).
- TGT_W, 3, target/position code width (clog2 of NUM_POS).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  shared step strobe; the same signal that gates the counter.
- cmd_valid  in  1  command present.
- cmd_target  in  TGT_W  requested position, 0..NUM_POS-1.
- cmd_ready  out  1  high only in IDLE.
- pos_onehot  in  POS_W  counter feedback (counter y[POS_W-1:0]).
- a  out  1  step request to the counter.
- busy  out  1  high in STEP or WAIT.
- done  out  1  one-cycle pulse: target reached.
- err  out  1  one-cycle pulse: command rejected or step check failed.
- steps  out  TGT_W  number of `a` pulses issued for the current or last command.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, a=0, busy=0, done=0, err=0, steps=0, cmd_ready=1 after release. Reset mid-operation aborts with no done/err pulse.
- Position decode (combinational):
  - 0000 -> 0; 0001 -> 1; 0010 -> 2; 0100 -> 3; 1000 -> 4.
  - Any other pattern is illegal.
- IDLE:
  - Accept when cmd_valid && cmd_ready. Latch target; clear steps.
  - target >= NUM_POS, or pos_onehot illegal at accept: err pulse next cycle, stay IDLE.
  - Decoded position == target: done pulse next cycle, zero steps, stay IDLE.
  - Otherwise go to STEP; expected = (pos+1) mod NUM_POS.
- STEP:
  - a = enable (combinational from state and enable; never high outside STEP).
  - On a cycle with enable=1: steps++ and go to WAIT. Stay in STEP while enable=0.
- WAIT (exactly one cycle; counter output is registered, so feedback is valid here):
  - pos_onehot illegal, or decoded != expected: err pulse, go to IDLE.
  - Decoded == target: done pulse, go to IDLE.
  - Otherwise expected = (expected+1) mod NUM_POS and go to STEP.
  - a=0 in WAIT, so no back-to-back pulses are possible.
- Wrap-around: distance is (target - start) mod NUM_POS, always 1..NUM_POS-1 steps. Example: 4 -> 1 is 2 steps (4->0->1).
- Step latency: with enable held high, each step costs 2 cycles (STEP, WAIT). A full 4-step move finishes 8 cycles after accept; done is asserted in the cycle after the final WAIT.
- Commands arriving while busy are not accepted (cmd_ready=0); the requester holds cmd_valid.
- done and err are mutually exclusive, each high for exactly one cycle.
- steps holds its value in IDLE until the next accept.

Decomposition:
- Shared package fsm_step_pkg:
  - NUM_POS/POS_W/TGT_W constants.
  - State encoding IDLE=0, STEP=1, WAIT=2.
  - onehot-to-code function returning code plus legal flag.
  - mod-NUM_POS increment function.
- One natural sub-module: pos_decode (one-hot -> code + legal). It is reusable by any block monitoring the counter.

Test Plan:
- Reset, counter at 0, enable=1, cmd target=3 -> exactly 3 `a` pulses, each followed by a 1-cycle gap; done at cycle 7 after accept; steps=3; err=0.
- Counter at 4, target=1 -> a pulses move 4->0->1; done; steps=2; err never high.
- Counter at 2, target=2 -> no `a`; done next cycle; steps=0. Target=6 -> err next cycle, no `a`, state IDLE.
- Target=4 from 0 with enable toggling 1,0,0,1,... -> `a` high only when enable=1 and in STEP; done after 4 pulses regardless of gaps.
- Target=3 from 0; bench forces pos_onehot=0011 (or holds 0001 when 0010 is expected) in the 2nd WAIT -> err pulse, a=0 afterwards, cmd_ready=1 next cycle.
- Assert reset_n=0 while in STEP with a=1 -> a, busy, done, err all drop to 0 immediately; after release, cmd_ready=1 and steps=0.

Source files
------------

// File: rtl/fsm_step_pkg.sv
// Shared constants, state encoding and position helpers for the step driver
// and anything else that watches the five-position pulse counter.
package fsm_step_pkg;

  localparam int unsigned NUM_POS = 5;
  localparam int unsigned POS_W   = NUM_POS - 1;
  localparam int unsigned TGT_W   = $clog2(NUM_POS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic             legal;
    logic [TGT_W-1:0] code;
  } pos_t;

  // Position k is one-hot bit k-1; all-zero is position 0; more than one bit set is illegal.
  function automatic pos_t onehot_to_pos(input logic [POS_W-1:0] oh);
    pos_t r;
    r.legal = ($countones(oh) <= 1);
    r.code  = '0;
    for (int unsigned i = 0; i < POS_W; i++) begin
      if (oh[i]) r.code = TGT_W'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [TGT_W-1:0] inc_mod(input logic [TGT_W-1:0] c);
    return (c == TGT_W'(NUM_POS - 1)) ? '0 : c + TGT_W'(1);
  endfunction

endpackage

// File: rtl/pos_decode.sv
// Combinational one-hot counter feedback to position code plus legality flag.
module pos_decode
  import fsm_step_pkg::*;
(
  input  logic [POS_W-1:0] onehot,
  output logic [TGT_W-1:0] code,
  output logic             legal
);

  pos_t pos;

  assign pos   = onehot_to_pos(onehot);
  assign code  = pos.code;
  assign legal = pos.legal;

endmodule

// File: rtl/fsm_step_driver.sv
// Command-driven initiator that walks the pulse counter to a target position,
// one enable-aligned pulse at a time, checking every step against feedback.
module fsm_step_driver
  import fsm_step_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic [TGT_W-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] pos_onehot,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [TGT_W-1:0] steps
);

  state_t           state, state_nxt;
  logic [TGT_W-1:0] target, target_nxt;
  logic [TGT_W-1:0] expected, expected_nxt;
  logic [TGT_W-1:0] steps_nxt;
  logic             done_nxt, err_nxt, busy_nxt;
  logic [TGT_W-1:0] pos_code;
  logic             pos_legal;

  pos_decode u_pos_decode (
    .onehot (pos_onehot),
    .code   (pos_code),
    .legal  (pos_legal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      target   <= '0;
      expected <= '0;
      steps    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      expected <= expected_nxt;
      steps    <= steps_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  // Feedback is only trusted at accept and in WAIT, where the registered counter has settled.
  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    expected_nxt = expected;
    steps_nxt    = steps;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    a            = 1'b0;
    cmd_ready    = 1'b0;

    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          target_nxt = cmd_target;
          steps_nxt  = '0;
          if ((cmd_target >= TGT_W'(NUM_POS)) || !pos_legal) begin
            err_nxt = 1'b1;
          end else if (pos_code == cmd_target) begin
            done_nxt = 1'b1;
          end else begin
            expected_nxt = inc_mod(pos_code);
            state_nxt    = STEP;
          end
        end
      end
      STEP: begin
        a = enable;
        if (enable) begin
          steps_nxt = steps + TGT_W'(1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!pos_legal || (pos_code != expected)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (pos_code == target) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          expected_nxt = inc_mod(expected);
          state_nxt    = STEP;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_fsm_step_driver.sv
// Bench for fsm_step_driver: environment counter, distance-based reference
// model compared every cycle, directed scenarios plus a randomized phase.
module tb_fsm_step_driver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_target = 3'd0;
  logic [3:0] pos_onehot;
  logic       cmd_ready, a, busy, done, err;
  logic [2:0] steps;

  int         cnt = 0;
  bit         inject = 1'b0;
  logic [3:0] bad = 4'd0;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: busy flag, gap (waiting for feedback), remaining pulses, expected position
  bit m_busy, m_gap, m_done, m_err;
  int m_left, m_exp, m_steps;

  bit accepted;
  int s_a, s_done, s_err, s_steps, s_ready;

  fsm_step_driver dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_target (cmd_target),
    .cmd_ready  (cmd_ready),
    .pos_onehot (pos_onehot),
    .a          (a),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps      (steps)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] enc(input int k);
    logic [3:0] v;
    v = 4'd0;
    if (k > 0) v[k-1] = 1'b1;
    return v;
  endfunction

  function automatic int decode(input logic [3:0] v);
    for (int k = 0; k < 5; k++) begin
      if (v == enc(k)) return k;
    end
    return -1;
  endfunction

  assign pos_onehot = inject ? bad : enc(cnt);

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_gap = 0; m_done = 0; m_err = 0;
    m_left = 0; m_exp = 0; m_steps = 0;
  endtask

  // One clock: compare at negedge, advance model, step environment counter after the edge.
  task automatic tick();
    bit nb, ng, nd, ne, stepped;
    int nl, nx, ns, fbp;
    @(negedge clock);
    s_a = a; s_done = done; s_err = err; s_steps = steps; s_ready = cmd_ready;
    chk("cmd_ready", s_ready, int'(!m_busy));
    chk("busy", int'(busy), int'(m_busy));
    chk("a", s_a, int'(m_busy && !m_gap && enable));
    chk("done", s_done, int'(m_done));
    chk("err", s_err, int'(m_err));
    chk("steps", s_steps, m_steps);
    fbp = decode(pos_onehot);
    nb = m_busy; ng = m_gap; nl = m_left; nx = m_exp; ns = m_steps;
    nd = 0; ne = 0; accepted = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        accepted = 1;
        ns = 0;
        if (cmd_target >= 3'd5 || fbp < 0) ne = 1;
        else if (fbp == int'(cmd_target)) nd = 1;
        else begin
          nb = 1; ng = 0;
          nl = (int'(cmd_target) - fbp + 5) % 5;
          nx = fbp;
        end
      end
    end else if (!m_gap) begin
      if (enable) begin ns++; ng = 1; nx = (nx + 1) % 5; end
    end else begin
      if (fbp != m_exp) begin ne = 1; nb = 0; end
      else begin
        nl--;
        if (nl == 0) begin nd = 1; nb = 0; end
        else ng = 0;
      end
    end
    stepped = a && enable;
    @(posedge clock);
    #1;
    if (stepped) cnt = (cnt + 1) % 5;
    m_busy = nb; m_gap = ng; m_left = nl; m_exp = nx; m_steps = ns;
    m_done = nd; m_err = ne;
    inject = 1'b0;
  endtask

  // mode 0: enable high; 1: enable 1,0,0 repeating; 2: random. fault_gap>0 corrupts that WAIT.
  task automatic run_cmd(input int t, input int mode, input int fault_gap,
                         output int cyc, output int pulses, output int got_done,
                         output int got_err, output int got_steps);
    int gaps;
    gaps = 0; cyc = -1; pulses = 0; got_done = 0; got_err = 0; got_steps = 0;
    cmd_valid = 1'b1;
    cmd_target = 3'(t);
    enable = 1'b1;
    accepted = 0;
    for (int w = 0; w < 20 && !accepted; w++) tick();
    chk("accept", int'(accepted), 1);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      enable = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 1) : 1'($urandom_range(0, 1));
      if (fault_gap > 0 && m_busy && m_gap) begin
        gaps++;
        if (gaps == fault_gap) begin inject = 1'b1; bad = 4'b0011; end
      end
      tick();
      pulses += s_a;
      if (s_done != 0 || s_err != 0) begin
        cyc = k; got_done = s_done; got_err = s_err; got_steps = s_steps;
        break;
      end
    end
    chk("run_completes", int'(cyc >= 0), 1);
  endtask

  int cyc, pulses, gd, ge, gs;

  initial begin
    model_reset();
    cnt = 0;
    #12;
    chk("rst_a", int'(a), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_steps", int'(steps), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    chk("ready_after_reset", s_ready, 1);

    // 0 -> 3 with enable held high
    cnt = 0;
    run_cmd(3, 0, 0, cyc, pulses, gd, ge, gs);
    chk("t1_cycles", cyc, 7);
    chk("t1_pulses", pulses, 3);
    chk("t1_done", gd, 1);
    chk("t1_err", ge, 0);
    chk("t1_steps", gs, 3);
    chk("t1_counter", cnt, 3);

    // wrap 4 -> 0 -> 1
    cnt = 4;
    run_cmd(1, 0, 0, cyc, pulses, gd, ge, gs);
    chk("t2_cycles", cyc, 5);
    chk("t2_pulses", pulses, 2);
    chk("t2_done", gd, 1);
    chk("t2_err", ge, 0);
    chk("t2_steps", gs, 2);
    chk("t2_counter", cnt, 1);

    // already there, then out-of-range target
    cnt = 2;
    run_cmd(2, 0, 0, cyc, pulses, gd, ge, gs);
    chk("t3_cycles", cyc, 1);
    chk("t3_pulses", pulses, 0);
    chk("t3_done", gd, 1);
    chk("t3_steps", gs, 0);
    run_cmd(6, 0, 0, cyc, pulses, gd, ge, gs);
    chk("t3b_cycles", cyc, 1);
    chk("t3b_err", ge, 1);
    chk("t3b_done", gd, 0);
    chk("t3b_pulses", pulses, 0);
    tick();
    chk("t3b_idle", s_ready, 1);

    // 0 -> 4 with enable gaps
    cnt = 0;
    run_cmd(4, 1, 0, cyc, pulses, gd, ge, gs);
    chk("t4_pulses", pulses, 4);
    chk("t4_done", gd, 1);
    chk("t4_steps", gs, 4);
    chk("t4_counter", cnt, 4);

    // corrupted feedback in the second WAIT
    cnt = 0;
    run_cmd(3, 0, 2, cyc, pulses, gd, ge, gs);
    chk("t5_cycles", cyc, 5);
    chk("t5_err", ge, 1);
    chk("t5_done", gd, 0);
    chk("t5_pulses", pulses, 2);
    enable = 1'b1;
    tick();
    chk("t5_a_after", s_a, 0);
    chk("t5_ready_after", s_ready, 1);

    // reset in the middle of a STEP with a high
    cnt = 0;
    cmd_valid = 1'b1;
    cmd_target = 3'd4;
    enable = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("t6_a_before", int'(a), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_a", int'(a), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err", int'(err), 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    chk("t6_ready", s_ready, 1);
    chk("t6_steps", s_steps, 0);

    // randomized phase
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 9) < 7);
      if (!cmd_valid && $urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_target = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      end
      if ($urandom_range(0, 29) == 0) begin
        inject = 1'b1;
        bad = 4'($urandom_range(0, 15));
      end
      tick();
      if (accepted) cmd_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
